matrix_mac_multiplier: RTL

//  Parametrised integer successor to matrix_multiplier: C[n x p] = A[n x m] * B[m x p], optionally + previous C.

---
 rtl/matrix_mac_multiplier.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/matrix_mac_multiplier.sv
// Signed matrix multiply-accumulate C = A*B (+ C_prev) through one shared MAC stepping (i,j,k),
// with stb/ack handshakes on A, B and C and per-element saturation flagged by a sticky sat_flag.
module matrix_mac_multiplier #(
  parameter int n         = 2,
  parameter int m         = 2,
  parameter int p         = 2,
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [0:WIDTH*n*m-1]     matrix_A,
  input  logic [0:WIDTH*m*p-1]     matrix_B,
  input  logic                     acc_mode,
  input  logic                     a_stb,
  input  logic                     b_stb,
  input  logic                     c_ack,
  output logic                     a_ack,
  output logic                     b_ack,
  output logic                     c_stb,
  output logic [0:OUT_WIDTH*n*p-1] matrix_C,
  output logic                     sat_flag
);

  localparam int ACC_W = 2*WIDTH + $clog2(m) + 1 + OUT_WIDTH;
  localparam int IW    = (n > 1) ? $clog2(n) : 1;
  localparam int JW    = (p > 1) ? $clog2(p) : 1;
  localparam int KW    = (m > 1) ? $clog2(m) : 1;

  localparam logic signed [ACC_W-1:0] C_MAX = {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] C_MIN = {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_LOAD,
    S_HOLD,
    S_MAC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic signed [WIDTH-1:0]     a_mat [n][m];
  logic signed [WIDTH-1:0]     b_mat [m][p];
  logic signed [OUT_WIDTH-1:0] c_mat [n][p];

  logic [IW-1:0]           i, i_next;
  logic [JW-1:0]           j, j_next;
  logic [KW-1:0]           k;
  logic signed [ACC_W-1:0] acc, acc_sum, reload, first_load;
  logic                    acc_mode_r;

  logic                        cap_a, cap_b, start;
  logic                        last_k, last_col, last_elem;
  logic                        clamp_hi, clamp_lo;
  logic signed [2*WIDTH-1:0]   prod;
  logic signed [OUT_WIDTH-1:0] c_write, c_next_el, c_first_el;

  always_ff @(posedge clk) begin
    if (rst) state <= S_LOAD;
    else     state <= state_next;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    cap_a      = 1'b0;
    cap_b      = 1'b0;
    start      = 1'b0;
    case (state)
      S_LOAD: begin
        cap_a = a_stb && !a_ack;
        cap_b = b_stb && !b_ack;
        if ((a_ack || cap_a) && (b_ack || cap_b)) state_next = S_HOLD;
      end
      S_HOLD: begin
        if (!a_stb && !b_stb) begin
          start      = 1'b1;
          state_next = S_MAC;
        end
      end
      S_MAC:   if (last_k) state_next = S_WRITE;
      S_WRITE: state_next = last_elem ? S_DONE : S_MAC;
      S_DONE:  if (c_ack) state_next = S_LOAD;
      default: state_next = S_LOAD;
    endcase
  end

  always_comb begin
    last_k    = (k == KW'(m - 1));
    last_col  = (j == JW'(p - 1));
    last_elem = last_col && (i == IW'(n - 1));
    j_next    = last_col ? '0 : j + JW'(1);
    i_next    = last_col ? i + IW'(1) : i;

    prod    = a_mat[i][k] * b_mat[k][j];
    acc_sum = acc + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};

    clamp_hi = (acc > C_MAX);
    clamp_lo = (acc < C_MIN);
    if (clamp_hi)      c_write = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (clamp_lo) c_write = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else               c_write = acc[OUT_WIDTH-1:0];

    // The next element's old value is still intact because C is rewritten in row-major order.
    c_next_el  = c_mat[i_next][j_next];
    c_first_el = c_mat[0][0];
    reload     = (acc_mode_r && !last_elem) ?
                 {{(ACC_W-OUT_WIDTH){c_next_el[OUT_WIDTH-1]}}, c_next_el} : '0;
    first_load = acc_mode ? {{(ACC_W-OUT_WIDTH){c_first_el[OUT_WIDTH-1]}}, c_first_el} : '0;
  end

  // NOTE: operand arrays carry no reset; they are only read after a capture has filled them.
  always_ff @(posedge clk) begin
    if (cap_a)
      for (int r = 0; r < n; r++)
        for (int c = 0; c < m; c++)
          a_mat[r][c] <= matrix_A[(r*m+c)*WIDTH +: WIDTH];
    if (cap_b)
      for (int r = 0; r < m; r++)
        for (int c = 0; c < p; c++)
          b_mat[r][c] <= matrix_B[(r*p+c)*WIDTH +: WIDTH];
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      c_stb      <= 1'b0;
      sat_flag   <= 1'b0;
      acc_mode_r <= 1'b0;
      acc        <= '0;
      i          <= '0;
      j          <= '0;
      k          <= '0;
      for (int r = 0; r < n; r++)
        for (int c = 0; c < p; c++)
          c_mat[r][c] <= '0;
    end else begin
      if (cap_a) a_ack <= 1'b1;
      if (cap_b) b_ack <= 1'b1;
      case (state)
        S_HOLD: begin
          if (start) begin
            a_ack      <= 1'b0;
            b_ack      <= 1'b0;
            i          <= '0;
            j          <= '0;
            k          <= '0;
            sat_flag   <= 1'b0;
            acc_mode_r <= acc_mode;
            acc        <= first_load;
          end
        end
        S_MAC: begin
          acc <= acc_sum;
          if (!last_k) k <= k + KW'(1);
        end
        S_WRITE: begin
          c_mat[i][j] <= c_write;
          if (clamp_hi || clamp_lo) sat_flag <= 1'b1;
          k   <= '0;
          acc <= reload;
          if (last_elem) begin
            c_stb <= 1'b1;
          end else begin
            i <= i_next;
            j <= j_next;
          end
        end
        S_DONE: if (c_ack) c_stb <= 1'b0;
        default: ;
      endcase
    end
  end

  for (genvar r = 0; r < n; r++) begin : g_row
    for (genvar c = 0; c < p; c++) begin : g_col
      assign matrix_C[(r*p+c)*OUT_WIDTH +: OUT_WIDTH] = c_mat[r][c];
    end
  end

endmodule
